// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state type and sizes for the AES-128 round sequencer.
// Used by both encrypt-only and AES_DECRYPT_EN builds.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;
  localparam int NR_DEFAULT  = 10;
  localparam int BLOCK_W     = 128;
  localparam int ROUND_IDX_W = 4;
endpackage

// File: rtl/aes_round_counter.sv
// aes_round_counter: round counter, key ROM index and last-round flag.
// Counts up for encrypt; counts down for decrypt (only driven in AES_DECRYPT_EN builds).
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_clear,
  input  logic                   i_idle,
  input  logic                   i_round,
  input  logic                   i_dec,
  output logic [ROUND_IDX_W-1:0] o_round_idx,
  output logic                   o_final
);
  localparam logic [ROUND_IDX_W-1:0] NR_L = ROUND_IDX_W'(NR);
  localparam logic [ROUND_IDX_W-1:0] ONE  = ROUND_IDX_W'(1);
  logic [ROUND_IDX_W-1:0] r_cnt;
  logic                   w_last;
  assign w_last      = r_cnt == (i_dec ? '0 : NR_L);
  assign o_final     = i_round && w_last;
  // In IDLE the index selects the key for the initial AddRoundKey.
  assign o_round_idx = i_idle ? (i_dec ? NR_L : '0) : r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_start) r_cnt <= i_dec ? NR_L - ONE : ONE;
    else if (i_clear) r_cnt <= '0;
    else if (i_round && !w_last) r_cnt <= i_dec ? r_cnt - ONE : r_cnt + ONE;
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer between block handshakes and the round datapath.
// Define AES_DECRYPT_EN to add the mode input and dp_dec output for inverse-cipher sequencing.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_DEFAULT,
  parameter int DW = BLOCK_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic [ROUND_IDX_W-1:0] round_idx,
  input  logic [DW-1:0]          key_in,
  output logic [DW-1:0]          dp_state,
  output logic                   dp_final,
  input  logic [DW-1:0]          dp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic                   busy
`ifdef AES_DECRYPT_EN
  ,
  input  logic                   mode,
  output logic                   dp_dec
`endif
);
  aes_state_e    r_state, w_next;
  logic [DW-1:0] r_data;
  logic          w_accept, w_final, w_dec;
`ifdef AES_DECRYPT_EN
  logic r_dec;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_dec <= 1'b0;
    else if (w_accept) r_dec <= mode;
  // Live mode in IDLE so the initial key index is right on the accept cycle.
  assign w_dec  = (r_state == IDLE) ? mode : r_dec;
  assign dp_dec = r_dec;
`else
  assign w_dec = 1'b0;
`endif
  assign w_accept  = in_valid && r_state == IDLE;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign dp_state  = r_data;
  assign out_data  = r_data;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? ROUND : IDLE;
      ROUND:   w_next = w_final ? DONE : ROUND;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_data <= in_data ^ key_in;
      else if (r_state == ROUND) r_data <= dp_result;
    end
  aes_round_counter #(.NR(NR)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept),
    .i_clear    (r_state == DONE && out_ready),
    .i_idle     (r_state == IDLE),
    .i_round    (r_state == ROUND),
    .i_dec      (w_dec),
    .o_round_idx(round_idx),
    .o_final    (w_final)
  );
  assign dp_final = w_final;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: bench acting as key ROM and round datapath, checked against a full AES-128 model.
// Decrypt scenarios are compiled only with AES_DECRYPT_EN.
module tb_aes_round_ctrl;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, dp_final, out_valid, busy;
  logic [127:0] in_data = '0, key_in, dp_state, dp_result, out_data;
  logic [3:0] round_idx;
`ifdef AES_DECRYPT_EN
  logic mode = 0, dp_dec;
`endif
  logic [7:0] sb [256], isb [256];
  logic [127:0] rk [16];
  int tests = 0, fails = 0, cyc = 0;
  int acc_q [$];
  logic [127:0] out_q [$];

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .round_idx(round_idx), .key_in(key_in), .dp_state(dp_state), .dp_final(dp_final),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef AES_DECRYPT_EN
    , .mode(mode), .dp_dec(dp_dec)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    if (out_valid && out_ready) out_q.push_back(out_data);
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] col, input logic inv);
    logic [7:0] m [4];
    logic [31:0] r;
    if (inv) begin m[0] = 14; m[1] = 11; m[2] = 13; m[3] = 9; end
    else begin m[0] = 2; m[1] = 3; m[2] = 1; m[3] = 1; end
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        r[31-8*j -: 8] = r[31-8*j -: 8] ^ gm(col[31-8*i -: 8], m[(i - j + 4) % 4]);
    return r;
  endfunction
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16], b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) b[w+4*c] = a[w+4*((c+w)%4)];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    if (!fin) for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix(r[127-32*c -: 32], 1'b0);
    return r ^ k;
  endfunction
  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16], b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) b[w+4*((c+w)%4)] = a[w+4*c];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[b[i]];
    r = r ^ k;
    if (!fin) for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix(r[127-32*c -: 32], 1'b1);
    return r;
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = enc_round(s, rk[r], r == 10);
    return s;
  endfunction

  assign key_in = rk[round_idx];
`ifdef AES_DECRYPT_EN
  assign dp_result = dp_dec ? dec_round(dp_state, key_in, dp_final) : enc_round(dp_state, key_in, dp_final);
`else
  assign dp_result = enc_round(dp_state, key_in, dp_final);
`endif

  task automatic init_sbox;
    logic [7:0] v, inv, s;
    for (int x = 0; x < 256; x++) begin
      v = 8'(x);
      inv = (x == 0) ? 8'h00 : 8'h01;
      if (x != 0) for (int i = 0; i < 254; i++) inv = gm(inv, v);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = v;
    end
  endtask
  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [127:0] d, output bit ok);
    ok = 0;
    in_data = d;
    in_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (dp_final !== 1'b0) begin fails++; $display("FAIL reset_dp_final got %b exp 0", dp_final); end
    tests++; if (round_idx !== 4'd0) begin fails++; $display("FAIL reset_round_idx got %0d exp 0", round_idx); end
    tests++; if (dp_state !== 128'h0) begin fails++; $display("FAIL reset_state got %h exp 0", dp_state); end
    rst_n = 1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_fips;
    set_key(FIPS_KEY);
    in_data = FIPS_PT;
    in_valid = 1;
    tests++; if (round_idx !== 4'd0) begin fails++; $display("FAIL fips_idx_accept got %0d exp 0", round_idx); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fips_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    for (int m = 0; m < 10; m++) begin
      tests++; if (round_idx !== 4'(m + 1)) begin fails++; $display("FAIL fips_seq_idx got %0d exp %0d", round_idx, m + 1); end
      tests++; if (dp_final !== (m == 9)) begin fails++; $display("FAIL fips_seq_final idx %0d got %b exp %b", m + 1, dp_final, m == 9); end
      tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL fips_early_valid got v=%b b=%b exp v=0 b=1", out_valid, busy); end
      tick();
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fips_latency out_valid got %b exp 1 after 10 edges", out_valid); end
    tests++; if (out_data !== FIPS_CT) begin fails++; $display("FAIL fips_ct got %h exp %h", out_data, FIPS_CT); end
    tests++; if (round_idx !== 4'd10 || dp_final !== 1'b0) begin fails++; $display("FAIL fips_done_idx got %0d/%b exp 10/0", round_idx, dp_final); end
    out_ready = 1;
    tick();
    out_ready = 0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL fips_return got r=%b v=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_backpressure;
    logic [127:0] pt, od;
    bit ok;
    int lat;
    set_key(rnd128());
    pt = rnd128();
    offer(pt, ok);
    wait_out(lat);
    tests++; if (!ok || lat != 10) begin fails++; $display("FAIL bp_latency got ok=%0d lat=%0d exp 1/10", ok, lat); end
    od = out_data;
    tests++; if (od !== aes_enc(pt)) begin fails++; $display("FAIL bp_ct got %h exp %h", od, aes_enc(pt)); end
    in_valid = 1;
    in_data = rnd128();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || out_data !== od) begin fails++; $display("FAIL bp_hold got v=%b d=%h exp 1/%h", out_valid, out_data, od); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    end
    out_ready = 1;
    tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_release got r=%b v=%b b=%b exp 1/0/0", in_ready, out_valid, busy); end
    in_valid = 0;
    out_ready = 0;
  endtask

  task automatic test_back_to_back;
    logic [127:0] p0, p1;
    p0 = rnd128();
    p1 = rnd128();
    acc_q.delete();
    out_q.delete();
    out_ready = 1;
    in_data = p0;
    in_valid = 1;
    for (int i = 0; i < 60 && acc_q.size() < 2; i++) begin
      tick();
      if (acc_q.size() == 1) in_data = p1;
    end
    in_valid = 0;
    tests++; if (acc_q.size() != 2) begin fails++; $display("FAIL b2b_accepts got %0d exp 2", acc_q.size()); end
    else begin
      tests++; if (acc_q[1] - acc_q[0] != 12) begin fails++; $display("FAIL b2b_spacing got %0d exp 12", acc_q[1] - acc_q[0]); end
    end
    for (int i = 0; i < 40 && out_q.size() < 2; i++) tick();
    tests++; if (out_q.size() != 2) begin fails++; $display("FAIL b2b_outputs got %0d exp 2", out_q.size()); end
    else begin
      tests++; if (out_q[0] !== aes_enc(p0)) begin fails++; $display("FAIL b2b_ct0 got %h exp %h", out_q[0], aes_enc(p0)); end
      tests++; if (out_q[1] !== aes_enc(p1)) begin fails++; $display("FAIL b2b_ct1 got %h exp %h", out_q[1], aes_enc(p1)); end
    end
    out_ready = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    logic [127:0] p2;
    bit ok;
    int lat;
    out_q.delete();
    out_ready = 1;
    offer(rnd128(), ok);
    for (int i = 0; i < 4; i++) tick();
    tests++; if (!ok || round_idx !== 4'd5) begin fails++; $display("FAIL rst_mid_round got ok=%0d idx=%0d exp 1/5", ok, round_idx); end
    #2 rst_n = 0;
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || round_idx !== 4'd0) begin
      fails++; $display("FAIL rst_mid_async got r=%b v=%b b=%b idx=%0d exp 1/0/0/0", in_ready, out_valid, busy, round_idx);
    end
    tick();
    rst_n = 1;
    p2 = rnd128();
    offer(p2, ok);
    wait_out(lat);
    tick();
    tests++; if (out_q.size() != 1) begin fails++; $display("FAIL rst_mid_outputs got %0d exp 1", out_q.size()); end
    else begin
      tests++; if (out_q[0] !== aes_enc(p2)) begin fails++; $display("FAIL rst_mid_ct got %h exp %h", out_q[0], aes_enc(p2)); end
    end
    out_ready = 0;
  endtask

  task automatic test_random;
    logic [127:0] pt;
    bit ok;
    int lat;
    for (int n = 0; n < 6; n++) begin
      set_key(rnd128());
      pt = rnd128();
      out_q.delete();
      offer(pt, ok);
      wait_out(lat);
      tests++; if (!ok || lat != 10) begin fails++; $display("FAIL rand_latency n=%0d got ok=%0d lat=%0d exp 1/10", n, ok, lat); end
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1;
      tick();
      out_ready = 0;
      tests++; if (out_q.size() != 1 || out_q[0] !== aes_enc(pt)) begin
        fails++; $display("FAIL rand_ct n=%0d got %h exp %h", n, (out_q.size() > 0) ? out_q[0] : 128'hx, aes_enc(pt));
      end
    end
  endtask

`ifdef AES_DECRYPT_EN
  task automatic test_decrypt;
    logic [127:0] pt;
    bit ok;
    int lat;
    set_key(FIPS_KEY);
    mode = 1;
    in_data = FIPS_CT;
    in_valid = 1;
    tests++; if (round_idx !== 4'd10) begin fails++; $display("FAIL dec_idx_accept got %0d exp 10", round_idx); end
    tick();
    in_valid = 0;
    mode = 0;
    tests++; if (dp_dec !== 1'b1) begin fails++; $display("FAIL dec_mode got %b exp 1", dp_dec); end
    for (int m = 0; m < 10; m++) begin
      tests++; if (round_idx !== 4'(9 - m)) begin fails++; $display("FAIL dec_seq_idx got %0d exp %0d", round_idx, 9 - m); end
      tests++; if (dp_final !== (m == 9) || out_valid !== 1'b0) begin fails++; $display("FAIL dec_seq_final got f=%b v=%b exp %b/0", dp_final, out_valid, m == 9); end
      tick();
    end
    tests++; if (out_valid !== 1'b1 || out_data !== FIPS_PT) begin fails++; $display("FAIL dec_pt got v=%b %h exp 1/%h", out_valid, out_data, FIPS_PT); end
    out_ready = 1;
    tick();
    out_ready = 0;
    set_key(rnd128());
    pt = rnd128();
    mode = 1;
    offer(aes_enc(pt), ok);
    mode = 0;
    wait_out(lat);
    tests++; if (!ok || lat != 10 || out_data !== pt) begin fails++; $display("FAIL dec_rand got lat=%0d %h exp 10/%h", lat, out_data, pt); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
`endif

  initial begin
    init_sbox();
    set_key(FIPS_KEY);
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AES_DECRYPT_EN
    test_decrypt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end
endmodule
